// File: rtl/nn_fa_pkg.sv
// Shared geometry defaults and helpers for the tile line buffer and its bench.
// Also carries the legality check applied to a buffer configuration.
package nn_fa_pkg;

   localparam int unsigned DEF_DW       = 8;
   localparam int unsigned DEF_W        = 512;
   localparam int unsigned DEF_TILE_N   = 4;
   localparam int unsigned DEF_STRIDE   = 2;
   localparam int unsigned DEF_NUM_ROWS = 6;

   // Bit offset of tile element (r,c); element (0,0) lands in the MSBs.
   function automatic int unsigned pix_offset(input int unsigned r, input int unsigned c,
                                              input int unsigned tile_n, input int unsigned dw);
      return (tile_n * tile_n - 1 - (r * tile_n + c)) * dw;
   endfunction

   function automatic bit geometry_ok(input int unsigned w, input int unsigned tile_n,
                                      input int unsigned stride, input int unsigned num_rows);
      return (stride > 0) && (tile_n >= stride) && (w >= tile_n) &&
             (((w - tile_n) % stride) == 0) && (num_rows >= tile_n + stride);
   endfunction

   function automatic int unsigned ptr_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tile_line_buffer_if.sv
// Pixel-in / tile-out handshake bundle of the tile line buffer.
// Signal names are from the buffer's point of view.
interface tile_line_buffer_if
   import nn_fa_pkg::*;
#(
   parameter int unsigned DW       = DEF_DW,
   parameter int unsigned TILE_N   = DEF_TILE_N,
   parameter int unsigned NUM_ROWS = DEF_NUM_ROWS
);
   localparam int unsigned TW = TILE_N * TILE_N * DW;
   localparam int unsigned FW = $clog2(NUM_ROWS + 1);

   logic [DW-1:0] i_data;
   logic          i_data_valid;
   logic          o_data_ready;
   logic [TW-1:0] o_tile;
   logic          o_tile_valid;
   logic          i_tile_ready;
   logic [FW-1:0] o_rows_filled;

   modport slave (
      input  i_data, i_data_valid, i_tile_ready,
      output o_data_ready, o_tile, o_tile_valid, o_rows_filled
   );

   modport master (
      output i_data, i_data_valid, i_tile_ready,
      input  o_data_ready, o_tile, o_tile_valid, o_rows_filled
   );

endinterface

// File: rtl/tile_window_mux.sv
// Combinational selection of a TILE_N x TILE_N window out of the row ring,
// starting at ring row `top` (oldest) and column `tile_col`.
module tile_window_mux
   import nn_fa_pkg::*;
#(
   parameter int unsigned DW       = DEF_DW,
   parameter int unsigned W        = DEF_W,
   parameter int unsigned TILE_N   = DEF_TILE_N,
   parameter int unsigned NUM_ROWS = DEF_NUM_ROWS,
   parameter int unsigned RW       = ptr_w(NUM_ROWS),
   parameter int unsigned CW       = ptr_w(W)
) (
   input  logic [NUM_ROWS-1:0][W-1:0][DW-1:0] ring,
   input  logic [RW-1:0]                      top,
   input  logic [CW-1:0]                      tile_col,
   output logic [TILE_N*TILE_N*DW-1:0]        tile
);

   always_comb begin
      logic [RW:0]   row_sum;
      logic [CW-1:0] col_idx;
      tile    = '0;
      row_sum = '0;
      col_idx = '0;
      for (int unsigned r = 0; r < TILE_N; r++) begin
         // Band rows wrap around the physical ring.
         row_sum = {1'b0, top} + (RW+1)'(r);
         if (row_sum >= (RW+1)'(NUM_ROWS))
            row_sum = row_sum - (RW+1)'(NUM_ROWS);
         for (int unsigned c = 0; c < TILE_N; c++) begin
            col_idx = tile_col + CW'(c);
            tile[pix_offset(r, c, TILE_N, DW) +: DW] = ring[row_sum[RW-1:0]][col_idx];
         end
      end
   end

endmodule

// File: rtl/tile_line_buffer.sv
// Ring of NUM_ROWS image rows emitting TILE_N x TILE_N tiles at STRIDE in both
// directions; row writes overlap tile reads of older rows.
module tile_line_buffer
   import nn_fa_pkg::*;
#(
   parameter int unsigned DW       = DEF_DW,
   parameter int unsigned W        = DEF_W,
   parameter int unsigned TILE_N   = DEF_TILE_N,
   parameter int unsigned STRIDE   = DEF_STRIDE,
   parameter int unsigned NUM_ROWS = DEF_NUM_ROWS
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   tile_line_buffer_if.slave  bus
);

   localparam int unsigned RW = ptr_w(NUM_ROWS);
   localparam int unsigned CW = ptr_w(W);
   localparam int unsigned FW = $clog2(NUM_ROWS + 1);
   localparam int unsigned TW = TILE_N * TILE_N * DW;

   if (!geometry_ok(W, TILE_N, STRIDE, NUM_ROWS)) begin : g_bad_geometry
      $error("tile_line_buffer: illegal W/TILE_N/STRIDE/NUM_ROWS combination");
   end

   logic [NUM_ROWS-1:0][W-1:0][DW-1:0] mem_q;

   logic [RW-1:0] wr_row_q, wr_row_d;
   logic [CW-1:0] wr_col_q, wr_col_d;
   logic [RW-1:0] top_q, top_d;
   logic [CW-1:0] tile_col_q, tile_col_d;
   logic [FW-1:0] rows_filled_q, rows_filled_d;
   logic          tile_valid_q, tile_valid_d;
   logic [TW-1:0] tile_q, tile_d;

   logic          data_ready;
   logic          wr_fire;
   logic          row_done;
   logic          tile_avail;
   logic          load;
   logic          retire;
   logic [TW-1:0] window;

   function automatic logic [RW-1:0] ring_add(input logic [RW-1:0] p, input int unsigned k);
      logic [RW:0] s;
      s = {1'b0, p} + (RW+1)'(k);
      if (s >= (RW+1)'(NUM_ROWS))
         s = s - (RW+1)'(NUM_ROWS);
      return s[RW-1:0];
   endfunction

   tile_window_mux #(
      .DW       (DW),
      .W        (W),
      .TILE_N   (TILE_N),
      .NUM_ROWS (NUM_ROWS),
      .RW       (RW),
      .CW       (CW)
   ) u_window (
      .ring     (mem_q),
      .top      (top_q),
      .tile_col (tile_col_q),
      .tile     (window)
   );

   always_comb begin
      data_ready = rows_filled_q < FW'(NUM_ROWS);
      wr_fire    = bus.i_data_valid && data_ready;
      row_done   = wr_fire && (wr_col_q == CW'(W - 1));
      tile_avail = rows_filled_q >= FW'(TILE_N);
      load       = tile_avail && (!tile_valid_q || bus.i_tile_ready);
      retire     = load && (tile_col_q == CW'(W - TILE_N));

      wr_row_d     = wr_row_q;
      wr_col_d     = wr_col_q;
      top_d        = top_q;
      tile_col_d   = tile_col_q;
      tile_valid_d = tile_valid_q;
      tile_d       = tile_q;

      if (wr_fire) begin
         if (row_done) begin
            wr_col_d = '0;
            wr_row_d = ring_add(wr_row_q, 1);
         end else begin
            wr_col_d = wr_col_q + CW'(1);
         end
      end

      // A row completing in the same cycle as a band retire nets to +1-STRIDE.
      rows_filled_d = rows_filled_q + FW'(row_done) - (retire ? FW'(STRIDE) : FW'(0));

      if (load) begin
         tile_d       = window;
         tile_valid_d = 1'b1;
         if (retire) begin
            tile_col_d = '0;
            top_d      = ring_add(top_q, STRIDE);
         end else begin
            tile_col_d = tile_col_q + CW'(STRIDE);
         end
      end else if (bus.i_tile_ready) begin
         tile_valid_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_row_q      <= '0;
         wr_col_q      <= '0;
         top_q         <= '0;
         tile_col_q    <= '0;
         rows_filled_q <= '0;
         tile_valid_q  <= 1'b0;
         tile_q        <= '0;
      end else begin
         wr_row_q      <= wr_row_d;
         wr_col_q      <= wr_col_d;
         top_q         <= top_d;
         tile_col_q    <= tile_col_d;
         rows_filled_q <= rows_filled_d;
         tile_valid_q  <= tile_valid_d;
         tile_q        <= tile_d;
      end
   end

   // Pixel storage carries no reset; resident rows are tracked by the pointers.
   always_ff @(posedge i_clk) begin
      if (wr_fire)
         mem_q[wr_row_q][wr_col_q] <= bus.i_data;
   end

   assign bus.o_data_ready  = data_ready;
   assign bus.o_tile        = tile_q;
   assign bus.o_tile_valid  = tile_valid_q;
   assign bus.o_rows_filled = rows_filled_q;

endmodule

// File: tb/tb_tile_line_buffer.sv
// Directed bench for tile_line_buffer at W=8, TILE_N=4, STRIDE=2, NUM_ROWS=6.
// Pixel value is (linear index % 256); expected tiles are written out by hand.
module tb_tile_line_buffer;

   localparam int unsigned DW       = 8;
   localparam int unsigned W        = 8;
   localparam int unsigned TILE_N   = 4;
   localparam int unsigned STRIDE   = 2;
   localparam int unsigned NUM_ROWS = 6;
   localparam int unsigned TW       = TILE_N * TILE_N * DW;

   typedef struct {
      string          name;
      int unsigned    band;
      int unsigned    col;
      logic [TW-1:0]  exp_tile;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   tile_line_buffer_if #(.DW(DW), .TILE_N(TILE_N), .NUM_ROWS(NUM_ROWS)) bus ();

   tile_line_buffer #(
      .DW       (DW),
      .W        (W),
      .TILE_N   (TILE_N),
      .STRIDE   (STRIDE),
      .NUM_ROWS (NUM_ROWS)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   int unsigned   n_vec = 0;
   int unsigned   n_err = 0;
   vec_t          tbl[12];
   logic [TW-1:0] got[$];
   logic          mon_en = 1'b0;

   function automatic logic [7:0] pix(input int unsigned i);
      return 8'(i % 256);
   endfunction

   task automatic check(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // Called just after a negedge; returns at the negedge following acceptance.
   task automatic push_pix(input logic [7:0] v);
      int unsigned t;
      t = 0;
      bus.i_data       = v;
      bus.i_data_valid = 1'b1;
      while (!bus.o_data_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!bus.o_data_ready) begin
         n_vec++;
         n_err++;
         $display("FAIL push_timeout: o_data_ready stuck at 0 for %0d cycles, want 1", t);
      end
      @(negedge clk);
   endtask

   task automatic push_range(input int unsigned first, input int unsigned last);
      for (int unsigned i = first; i <= last; i++)
         push_pix(pix(i));
   endtask

   task automatic reset_pulse();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Tile handshake monitor, sampled mid-cycle.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (mon_en && bus.o_tile_valid && bus.i_tile_ready)
            got.push_back(bus.o_tile);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{"b0c0", 0, 0, 128'h00010203_08090A0B_10111213_18191A1B};
      tbl[1]  = '{"b0c2", 0, 2, 128'h02030405_0A0B0C0D_12131415_1A1B1C1D};
      tbl[2]  = '{"b0c4", 0, 4, 128'h04050607_0C0D0E0F_14151617_1C1D1E1F};
      tbl[3]  = '{"b1c0", 1, 0, 128'h10111213_18191A1B_20212223_28292A2B};
      tbl[4]  = '{"b1c2", 1, 2, 128'h12131415_1A1B1C1D_22232425_2A2B2C2D};
      tbl[5]  = '{"b1c4", 1, 4, 128'h14151617_1C1D1E1F_24252627_2C2D2E2F};
      tbl[6]  = '{"b2c0", 2, 0, 128'h20212223_28292A2B_30313233_38393A3B};
      tbl[7]  = '{"b2c2", 2, 2, 128'h22232425_2A2B2C2D_32333435_3A3B3C3D};
      tbl[8]  = '{"b2c4", 2, 4, 128'h24252627_2C2D2E2F_34353637_3C3D3E3F};
      tbl[9]  = '{"b3c0", 3, 0, 128'h30313233_38393A3B_40414243_48494A4B};
      tbl[10] = '{"b3c2", 3, 2, 128'h32333435_3A3B3C3D_42434445_4A4B4C4D};
      tbl[11] = '{"b3c4", 3, 4, 128'h34353637_3C3D3E3F_44454647_4C4D4E4F};

      rst_n            = 1'b0;
      bus.i_data       = '0;
      bus.i_data_valid = 1'b0;
      bus.i_tile_ready = 1'b0;
      repeat (2) @(negedge clk);

      // Reset values
      check("rst_valid",  TW'(bus.o_tile_valid),  '0);
      check("rst_tile",   bus.o_tile,             '0);
      check("rst_filled", TW'(bus.o_rows_filled), '0);
      check("rst_ready",  TW'(bus.o_data_ready),  TW'(1));
      rst_n = 1'b1;
      @(negedge clk);

      // First tile: valid rises one edge after the fourth row completes
      push_range(0, 31);
      bus.i_data_valid = 1'b0;
      check("first_filled",   TW'(bus.o_rows_filled), TW'(4));
      check("first_latency0", TW'(bus.o_tile_valid),  '0);
      @(negedge clk);
      check("first_valid", TW'(bus.o_tile_valid), TW'(1));
      check("first_tile",  bus.o_tile,            tbl[0].exp_tile);

      // Back-to-back tiles across the band, then retire
      bus.i_tile_ready = 1'b1;
      @(negedge clk);
      check("b2b_c2", bus.o_tile, tbl[1].exp_tile);
      @(negedge clk);
      check("b2b_c4",        bus.o_tile,             tbl[2].exp_tile);
      check("b2b_c4_filled", TW'(bus.o_rows_filled), TW'(2));
      @(negedge clk);
      check("b2b_drop_valid", TW'(bus.o_tile_valid),  '0);
      check("b2b_drop_filled", TW'(bus.o_rows_filled), TW'(2));

      // Backpressure and full ring
      reset_pulse();
      bus.i_tile_ready = 1'b0;
      push_range(0, 39);
      check("bp_hold_40", bus.o_tile, tbl[0].exp_tile);
      push_range(40, 47);
      check("full_ready",  TW'(bus.o_data_ready),  '0);
      check("full_filled", TW'(bus.o_rows_filled), TW'(6));
      check("bp_hold_48",  bus.o_tile,             tbl[0].exp_tile);
      bus.i_data = 8'hEE;
      repeat (3) @(negedge clk);
      bus.i_data_valid = 1'b0;
      check("full_ignore_filled", TW'(bus.o_rows_filled), TW'(6));
      check("bp_hold_extra",      bus.o_tile,             tbl[0].exp_tile);
      bus.i_tile_ready = 1'b1;
      @(negedge clk);
      check("full_c2", bus.o_tile, tbl[1].exp_tile);
      @(negedge clk);
      check("full_c4",            bus.o_tile,             tbl[2].exp_tile);
      check("ready_after_retire", TW'(bus.o_data_ready),  TW'(1));
      check("retire_filled",      TW'(bus.o_rows_filled), TW'(4));
      @(negedge clk);
      check("full_b1c0", bus.o_tile, tbl[3].exp_tile);
      bus.i_tile_ready = 1'b0;

      // Reset mid-tile takes effect without a clock edge
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_valid",  TW'(bus.o_tile_valid),  '0);
      check("midrst_tile",   bus.o_tile,             '0);
      check("midrst_filled", TW'(bus.o_rows_filled), '0);
      check("midrst_ready",  TW'(bus.o_data_ready),  TW'(1));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Retire coinciding with a row completion
      push_range(0, 46);
      bus.i_data_valid = 1'b0;
      check("sim_pre_filled", TW'(bus.o_rows_filled), TW'(5));
      bus.i_tile_ready = 1'b1;
      @(negedge clk);
      check("sim_c2", bus.o_tile, tbl[1].exp_tile);
      push_pix(pix(47));
      bus.i_data_valid = 1'b0;
      check("sim_filled_5to4", TW'(bus.o_rows_filled), TW'(4));
      check("sim_c4",          bus.o_tile,             tbl[2].exp_tile);

      // Ring wrap: ten rows streamed with the consumer always ready
      reset_pulse();
      bus.i_tile_ready = 1'b1;
      got.delete();
      mon_en = 1'b1;
      push_range(0, 79);
      bus.i_data_valid = 1'b0;
      for (int unsigned w = 0; w < 40 && got.size() < 12; w++)
         @(negedge clk);
      repeat (4) @(negedge clk);
      mon_en = 1'b0;
      check("wrap_count",  TW'(got.size()),        TW'(12));
      check("wrap_filled", TW'(bus.o_rows_filled), TW'(2));
      for (int unsigned i = 0; i < 12; i++) begin
         if (i < got.size()) begin
            check({"wrap_", tbl[i].name}, got[i], tbl[i].exp_tile);
         end else begin
            n_vec++;
            n_err++;
            $display("FAIL wrap_%s: tile missing, want %h", tbl[i].name, tbl[i].exp_tile);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
